// File: rtl/shift_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : shift_seq_ctrl_if
//  Description : Request/response handshake bundle for the multi-cycle
//                shift sequencer (request side, result side, busy flag).
//  Revision    : 1.0 - initial release
// ============================================================================
interface shift_seq_ctrl_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_op;
    logic            in_word;
    logic [XLEN-1:0] in_data;
    logic [5:0]      in_shamt;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_data;
    logic            busy;

    // Issue logic / consumer side
    modport master (
        output in_valid, in_op, in_word, in_data, in_shamt, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    // Shift sequencer side
    modport slave (
        input  in_valid, in_op, in_word, in_data, in_shamt, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : shift_seq_ctrl
//  Description : Multi-cycle 64-bit shifter for the RV64 execute stage.
//                The shift amount is decomposed into 1/2/4/8/16/32-bit
//                stages, one stage applied per cycle to a held operand.
//                Supports SLL/SRL/SRA and the W forms SLLW/SRLW/SRAW.
//                Optional macro EARLY_EXIT_EN: finish as soon as the
//                remaining shamt bits are all zero (same results).
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_seq_ctrl #(
    parameter int XLEN   = 64,
    parameter int NSTAGE = 6
) (
    input  wire              clk,
    input  wire              rst,
    shift_seq_ctrl_if.slave  bus
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SHIFT  = 2'd1;
    localparam logic [1:0] c_DONE   = 2'd2;
    localparam logic [2:0] c_LAST_K = 3'(NSTAGE - 1);

    localparam logic [1:0] c_OP_SRL = 2'b01;
    localparam logic [1:0] c_OP_SRA = 2'b11;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;

    logic [XLEN-1:0] r_data;
    logic [5:0]      r_shamt;
    logic [2:0]      r_k;
    logic [1:0]      r_op;
    logic            r_word;

    logic            w_in_ready;
    logic            w_out_valid;
    logic            w_busy;
    logic            w_accept;

    logic [XLEN-1:0] w_eff_data;
    logic [5:0]      w_eff_shamt;
    logic [5:0]      w_step;
    logic [XLEN-1:0] w_shifted;
    logic [XLEN-1:0] w_out_data;

    assign w_accept = bus.in_valid & w_in_ready;

    // Word forms ignore shamt[5]; the upper half is sign-filled only for SRAW
    // so that right shifts pull the correct bits into the low word.
    always_comb begin
        w_eff_data  = bus.in_data;
        w_eff_shamt = bus.in_shamt;
        if (bus.in_word) begin
            w_eff_shamt = {1'b0, bus.in_shamt[4:0]};
            w_eff_data  = {((bus.in_op == c_OP_SRA) ? {32{bus.in_data[31]}} : 32'd0),
                           bus.in_data[31:0]};
        end
    end

    // One binary stage of the shift: distance 2^k in the selected direction.
    always_comb begin
        w_step = 6'd1 << r_k;
        case (r_op)
            c_OP_SRL: w_shifted = r_data >> w_step;
            c_OP_SRA: w_shifted = $signed(r_data) >>> w_step;
            default:  w_shifted = r_data << w_step;   // SLL and reserved 10
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
`ifdef EARLY_EXIT_EN
                    w_state_nxt = (w_eff_shamt == 6'd0) ? c_DONE : c_SHIFT;
`else
                    w_state_nxt = c_SHIFT;
`endif
                end
            end
            c_SHIFT: begin
`ifdef EARLY_EXIT_EN
                if ((r_k == c_LAST_K) || (((r_shamt >> r_k) >> 1) == 6'd0)) begin
                    w_state_nxt = c_DONE;
                end
`else
                if (r_k == c_LAST_K) begin
                    w_state_nxt = c_DONE;
                end
`endif
            end
            c_DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state.
    always_comb begin
        w_in_ready  = (r_state == c_IDLE) & ~rst;
        w_out_valid = (r_state == c_DONE);
        w_busy      = (r_state == c_SHIFT) | (r_state == c_DONE);
    end

    // Operand, shamt, op and stage counter: loaded on accept, stepped in SHIFT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_shamt <= '0;
            r_k     <= '0;
            r_op    <= '0;
            r_word  <= 1'b0;
        end else if (r_state == c_IDLE) begin
            if (w_accept) begin
                r_data  <= w_eff_data;
                r_shamt <= w_eff_shamt;
                r_k     <= '0;
                r_op    <= bus.in_op;
                r_word  <= bus.in_word;
            end
        end else if (r_state == c_SHIFT) begin
            if (r_shamt[r_k]) begin
                r_data <= w_shifted;
            end
            r_k <= r_k + 3'd1;
        end
    end

    // W-form results are the sign-extended low word of the held register.
    always_comb begin
        w_out_data = r_word ? {{32{r_data[31]}}, r_data[31:0]} : r_data;
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_data;
    assign bus.busy      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_seq_ctrl
//  Description : Self-checking bench for shift_seq_ctrl: directed cases,
//                backpressure, mid-operation reset and random operations
//                compared against a behavioural shift model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_seq_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    shift_seq_ctrl_if #(.XLEN(64)) bus ();

    shift_seq_ctrl #(.XLEN(64), .NSTAGE(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference result straight from the instruction semantics.
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic word,
                                               input logic [63:0] data, input logic [5:0] shamt);
        logic [31:0]        w;
        logic signed [31:0] ws;
        logic [31:0]        r32;
        logic signed [63:0] ds;
        logic [63:0]        r64;
        if (word) begin
            w  = data[31:0];
            ws = data[31:0];
            case (op)
                2'b01:   r32 = w >> shamt[4:0];
                2'b11:   r32 = ws >>> shamt[4:0];
                default: r32 = w << shamt[4:0];
            endcase
            r64 = {{32{r32[31]}}, r32};
        end else begin
            ds = data;
            case (op)
                2'b01:   r64 = data >> shamt;
                2'b11:   r64 = ds >>> shamt;
                default: r64 = data << shamt;
            endcase
        end
        return r64;
    endfunction

    // Cycle (counted from accept = 0) in which out_valid first rises.
    function automatic int ref_latency(input logic word, input logic [5:0] shamt);
        int          hi;
        logic [5:0]  s;
        s  = word ? {1'b0, shamt[4:0]} : shamt;
        hi = -1;
        for (int i = 0; i < 6; i++) if (s[i]) hi = i;
`ifdef EARLY_EXIT_EN
        return (hi < 0) ? 1 : 2 + hi;
`else
        return 7;
`endif
    endfunction

    // Issue one operation, wait for its result, apply `hold` cycles of
    // backpressure, then complete the handshake and check the return to IDLE.
    task automatic run_op(input string tag, input logic [1:0] op, input logic word,
                          input logic [63:0] data, input logic [5:0] shamt, input int hold);
        logic [63:0] exp;
        logic [63:0] first;
        int          cyc;
        exp = ref_result(op, word, data, shamt);
        @(negedge clk);
        check({tag, ":in_ready_idle"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid  = 1'b1;
        bus.in_op     = op;
        bus.in_word   = word;
        bus.in_data   = data;
        bus.in_shamt  = shamt;
        bus.out_ready = (hold == 0);
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        // Garbage on the request side while busy must be ignored.
        while (!bus.out_valid && cyc < 20) begin
            bus.in_valid = 1'($urandom);
            bus.in_op    = 2'($urandom);
            bus.in_word  = 1'($urandom);
            bus.in_data  = {$urandom, $urandom};
            bus.in_shamt = 6'($urandom);
            @(negedge clk);
            cyc++;
        end
        check({tag, ":latency"}, 64'(cyc), 64'(ref_latency(word, shamt)));
        check({tag, ":data"}, bus.out_data, exp);
        first = bus.out_data;
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = {$urandom, $urandom};
            check({tag, ":hold_data"}, bus.out_data, first);
            check({tag, ":hold_busy"}, {bus.busy, bus.in_ready, bus.out_valid}, 3'b101);
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, ":post_hs"}, {bus.out_valid, bus.in_ready, bus.busy}, 3'b010);
    endtask

    initial begin
        logic [1:0] rop;
        logic [5:0] rsh;
        int         hold;
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_op     = 2'b00;
        bus.in_word   = 1'b0;
        bus.in_data   = '0;
        bus.in_shamt  = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("reset_outputs", {bus.out_valid, bus.busy, bus.in_ready}, 3'b000);
        check("reset_data", bus.out_data, 64'd0);
        rst = 1'b0;
        #1;
        check("reset_release_ready", 64'(bus.in_ready), 64'd1);

        run_op("sll63",   2'b00, 1'b0, 64'h1, 6'd63, 0);
        run_op("sra4",    2'b11, 1'b0, 64'h8000_0000_0000_0000, 6'd4, 0);
        run_op("srl4",    2'b01, 1'b0, 64'h8000_0000_0000_0000, 6'd4, 0);
        run_op("sllw31",  2'b00, 1'b1, 64'h1, 6'd31, 0);
        run_op("srlw31",  2'b01, 1'b1, 64'hFFFF_FFFF_8000_0000, 6'd31, 0);
        run_op("sraw63",  2'b11, 1'b1, 64'h0000_0000_8000_0000, 6'd63, 0);
        run_op("rsvd_op", 2'b10, 1'b0, 64'h0123_4567_89AB_CDEF, 6'd12, 0);
        run_op("bp5",     2'b11, 1'b0, 64'hC3C3_0000_1234_5678, 6'd9, 5);
        run_op("sh0",     2'b11, 1'b0, 64'h8765_4321_0FED_CBA9, 6'd0, 0);
        run_op("sh0w",    2'b00, 1'b1, 64'hDEAD_BEEF_8000_0001, 6'd32, 1);
        run_op("sh32",    2'b01, 1'b0, 64'hFFFF_0000_AAAA_5555, 6'd32, 0);

        // Reset asserted during cycle 3 of an SRA aborts the operation.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = 2'b11;
        bus.in_word  = 1'b0;
        bus.in_data  = 64'hF0F0_F0F0_F0F0_F0F0;
        bus.in_shamt = 6'd63;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_reset_busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        #1;
        check("abort_outputs", {bus.out_valid, bus.busy, bus.in_ready}, 3'b000);
        check("abort_data", bus.out_data, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_release_ready", 64'(bus.in_ready), 64'd1);
        run_op("after_rst", 2'b00, 1'b0, 64'h3, 6'd1, 0);
        check("after_rst_const", ref_result(2'b00, 1'b0, 64'h3, 6'd1), 64'h6);

        // Random operations against the model.
        for (int n = 0; n < 40; n++) begin
            rop  = 2'($urandom);
            rsh  = 6'($urandom);
            hold = $urandom_range(0, 3);
            run_op("rand", rop, 1'($urandom), {$urandom, $urandom}, rsh, hold);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
